// File: rtl/cb_arb_pkg.sv
// Shared types and helpers for the cross-bar arbiters.
package cb_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} wr_arb_state_t;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: scans last+1, last+2, ... mod N.
module rr_arbiter
  import cb_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] w_idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = IW'((32'(last) + k) % N);
      if (!any && req[w_idx]) begin
        any     = 1'b1;
        gnt_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/slave_wr_arbiter.sv
// Per-slave write-channel arbiter: round-robin grant among masters addressing
// SLAVE_ID, req/ack handshake to the slave, one-cycle ack or timeout error back.
module slave_wr_arbiter
  import cb_arb_pkg::*;
#(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned SLAVE_ID   = 0,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned SW        = sel_width(MASTER_NUM)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [MASTER_NUM-1:0]        m_req,
  input  logic [MASTER_NUM*SW-1:0]     m_sel,
  input  logic [MASTER_NUM*AWIDTH-1:0] m_addr,
  input  logic [MASTER_NUM*DWIDTH-1:0] m_wdata,
  output logic [MASTER_NUM-1:0]        m_ack,
  output logic [MASTER_NUM-1:0]        m_err,
  output logic                         s_req,
  output logic [AWIDTH-1:0]            s_addr,
  output logic [DWIDTH-1:0]            s_wdata,
  input  logic                         s_ack,
  output logic [SW-1:0]                grant_id,
  output logic                         busy
);

  localparam int unsigned CW = sel_width(TIMEOUT);

  wr_arb_state_t         r_state, w_next;
  logic [MASTER_NUM-1:0] w_elig;
  logic [SW-1:0]         w_win;
  logic                  w_any;
  logic                  w_tmo;

  logic [SW-1:0]         r_last;
  logic [SW-1:0]         r_gid;
  logic [CW-1:0]         r_cnt;
  logic                  r_sreq;
  logic [AWIDTH-1:0]     r_addr;
  logic [DWIDTH-1:0]     r_wdata;
  logic [MASTER_NUM-1:0] r_ack;
  logic [MASTER_NUM-1:0] r_err;

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      w_elig[i] = m_req[i] && (m_sel[i*SW +: SW] == SW'(SLAVE_ID));
    end
  end

  // Pointer lives here so it advances only when a transaction completes.
  rr_arbiter #(
    .N  (MASTER_NUM),
    .IW (SW)
  ) u_rr (
    .req     (w_elig),
    .last    (r_last),
    .gnt_idx (w_win),
    .any     (w_any)
  );

  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = WAIT;
      WAIT:    if (s_ack || w_tmo) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last  <= SW'(MASTER_NUM - 1);
      r_gid   <= '0;
      r_cnt   <= '0;
      r_sreq  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gid   <= w_win;
            r_addr  <= m_addr[w_win*AWIDTH +: AWIDTH];
            r_wdata <= m_wdata[w_win*DWIDTH +: DWIDTH];
            r_sreq  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          // Ack takes precedence over a coincident timeout.
          if (s_ack) begin
            r_sreq       <= 1'b0;
            r_ack[r_gid] <= 1'b1;
            r_last       <= r_gid;
          end else if (w_tmo) begin
            r_sreq       <= 1'b0;
            r_err[r_gid] <= 1'b1;
            r_last       <= r_gid;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_req    = r_sreq;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign m_ack    = r_ack;
  assign m_err    = r_err;
  assign grant_id = r_gid;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_slave_wr_arbiter.sv
// Self-checking bench for slave_wr_arbiter: vector table with scoreboard plus
// hand-written sequences for sel filtering, reset mid-WAIT and round-robin.
module tb_slave_wr_arbiter;

  localparam int unsigned MN  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SID = 1;
  localparam int unsigned TO  = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [MN-1:0] m_req;
  logic [MN-1:0] m_sel;
  logic [63:0]   m_addr;
  logic [63:0]   m_wdata;
  logic [MN-1:0] m_ack;
  logic [MN-1:0] m_err;
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ack;
  logic [0:0]    grant_id;
  logic          busy;

  slave_wr_arbiter #(
    .AWIDTH     (AW),
    .DWIDTH     (DW),
    .MASTER_NUM (MN),
    .SLAVE_ID   (SID),
    .TIMEOUT    (TO)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .m_req    (m_req),
    .m_sel    (m_sel),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  sel;
    logic [31:0] a0, a1, d0, d1;
    int          ack_lat;   // WAIT cycles before s_ack; -1 = never
    int          exp_gnt;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [0:0]  gnt;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  ack;
    logic [1:0]  err;
    int          hi;
  } exp_t;

  exp_t sb[$];
  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    int   hi;
    m_req   = v.req;
    m_sel   = v.sel;
    m_addr  = {v.a1, v.a0};
    m_wdata = {v.d1, v.d0};
    e.gnt   = 1'(v.exp_gnt);
    e.addr  = (v.exp_gnt == 1) ? v.a1 : v.a0;
    e.data  = (v.exp_gnt == 1) ? v.d1 : v.d0;
    e.ack   = v.exp_err ? 2'b00 : 2'(1 << v.exp_gnt);
    e.err   = v.exp_err ? 2'(1 << v.exp_gnt) : 2'b00;
    e.hi    = (v.ack_lat < 0) ? int'(TO) : v.ack_lat + 1;
    sb.push_back(e);

    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_req && lat < 20);
    check("grant_latency", 64'(lat), 64'(1));
    e = sb.pop_front();
    if (!s_req) return;

    check("grant_id", 64'(grant_id), 64'(e.gnt));
    check("s_addr", 64'(s_addr), 64'(e.addr));
    check("s_wdata", 64'(s_wdata), 64'(e.data));
    check("busy_wait", 64'(busy), 64'(1));

    // Master walks away mid-transaction; latched values must hold.
    m_req   = '0;
    m_addr  = ~m_addr;
    m_wdata = ~m_wdata;
    hi = 1;
    while (1) begin
      s_ack = (v.ack_lat == hi - 1);
      tick();
      s_ack = 1'b0;
      if (!s_req || hi > int'(TO) + 4) break;
      hi++;
    end
    check("s_req_high_cycles", 64'(hi), 64'(e.hi));
    check("s_addr_stable", 64'(s_addr), 64'(e.addr));
    check("s_wdata_stable", 64'(s_wdata), 64'(e.data));
    check("m_ack_pulse", 64'(m_ack), 64'(e.ack));
    check("m_err_pulse", 64'(m_err), 64'(e.err));
    check("busy_done", 64'(busy), 64'(1));
    tick();
    check("m_ack_cleared", 64'(m_ack), 64'(0));
    check("m_err_cleared", 64'(m_err), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int ngr;
    int multi;
    logic prev;
    int gcyc[4];
    logic [0:0] gid[4];
    logic [0:0] rr_exp[4];

    aresetn = 1'b0;
    m_req   = '0;
    m_sel   = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ack   = 1'b0;

    vt[0] = '{req:2'b01, sel:2'b01, a0:32'h8000_0010, a1:32'h0, d0:32'hA5A5_0001, d1:32'h0,
              ack_lat:3, exp_gnt:0, exp_err:1'b0};
    vt[1] = '{req:2'b10, sel:2'b10, a0:32'h1111_1111, a1:32'h1234_0000, d0:32'h2222_2222, d1:32'hDEAD_BEEF,
              ack_lat:0, exp_gnt:1, exp_err:1'b0};
    vt[2] = '{req:2'b11, sel:2'b11, a0:32'h0000_0100, a1:32'h0000_0200, d0:32'h0000_00AA, d1:32'h0000_00BB,
              ack_lat:1, exp_gnt:0, exp_err:1'b0};
    vt[3] = '{req:2'b11, sel:2'b11, a0:32'hA000_0004, a1:32'hB000_0008, d0:32'h0102_0304, d1:32'h0506_0708,
              ack_lat:2, exp_gnt:1, exp_err:1'b0};
    vt[4] = '{req:2'b11, sel:2'b10, a0:32'hC000_0000, a1:32'hD000_0000, d0:32'hCAFE_0000, d1:32'hF00D_0000,
              ack_lat:-1, exp_gnt:1, exp_err:1'b1};
    vt[5] = '{req:2'b01, sel:2'b01, a0:32'h0000_FFFC, a1:32'h0, d0:32'h7777_7777, d1:32'h0,
              ack_lat:int'(TO) - 1, exp_gnt:0, exp_err:1'b0};
    vt[6] = '{req:2'b11, sel:2'b01, a0:32'h4000_0040, a1:32'h5000_0050, d0:32'h1357_9BDF, d1:32'h2468_ACE0,
              ack_lat:5, exp_gnt:0, exp_err:1'b0};

    tick();
    tick();
    check("rst_s_req", 64'(s_req), 64'(0));
    check("rst_m_ack", 64'(m_ack), 64'(0));
    check("rst_m_err", 64'(m_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_s_addr", 64'(s_addr), 64'(0));
    check("rst_s_wdata", 64'(s_wdata), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Request aimed at another slave is ignored.
    m_req = 2'b10;
    m_sel = 2'b00;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_req || busy) bad++;
    end
    check("sel_filter_active_cycles", 64'(bad), 64'(0));
    m_req = '0;
    tick();

    // Reset in WAIT aborts silently and restores master-0 priority.
    m_req   = 2'b10;
    m_sel   = 2'b10;
    m_addr  = {32'h9999_0000, 32'h8888_0000};
    m_wdata = {32'h6666_0000, 32'h5555_0000};
    tick();
    check("rstw_s_req", 64'(s_req), 64'(1));
    check("rstw_grant", 64'(grant_id), 64'(1));
    tick();
    aresetn = 1'b0;
    tick();
    check("rstw_s_req_after", 64'(s_req), 64'(0));
    check("rstw_m_ack_after", 64'(m_ack), 64'(0));
    check("rstw_m_err_after", 64'(m_err), 64'(0));
    check("rstw_busy_after", 64'(busy), 64'(0));
    check("rstw_grant_after", 64'(grant_id), 64'(0));
    aresetn = 1'b1;
    m_req   = 2'b11;
    m_sel   = 2'b11;
    tick();
    check("rstw_regrant_req", 64'(s_req), 64'(1));
    check("rstw_regrant_id", 64'(grant_id), 64'(0));
    check("rstw_regrant_addr", 64'(s_addr), 64'(32'h8888_0000));
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("rstw_ack", 64'(m_ack), 64'(2'b01));
    m_req = '0;
    tick();
    tick();

    // Continuous requests from both masters with a one-cycle slave.
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    m_req = 2'b11;
    m_sel = 2'b11;
    rr_exp[0] = 1'b0; rr_exp[1] = 1'b1; rr_exp[2] = 1'b0; rr_exp[3] = 1'b1;
    ngr = 0;
    multi = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      tick();
      if ($countones(m_ack | m_err) > 1) multi++;
      if (s_req && !prev) begin
        gid[ngr]  = grant_id;
        gcyc[ngr] = c;
        ngr++;
      end
      prev  = s_req;
      s_ack = s_req;
    end
    s_ack = 1'b0;
    m_req = '0;
    check("rr_grant_count", 64'(ngr), 64'(4));
    for (int k = 0; k < ngr; k++) check("rr_order", 64'(gid[k]), 64'(rr_exp[k]));
    for (int k = 1; k < ngr; k++) check("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(3));
    check("rr_onehot_resp", 64'(multi), 64'(0));
    tick();
    tick();

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
